// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding, default
// phase timings and the latch readback comparison.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_RESP  = 3'd5
    } sr_state_t;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_CNT_W     = 4;

    // A healthy latch shows Q == target and Qn == ~target.
    function automatic logic fb_mismatch(input logic target, input logic q, input logic qn);
        return ~((q == target) && (qn == ~target));
    endfunction

endpackage

// File: rtl/sr_phase_cnt.sv
// Loadable down-counter timing each driver phase; zero marks the last
// cycle of the phase.
module sr_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    assign count = cnt_r;
    assign zero  = (cnt_r == {CNT_W{1'b0}});

    // Phase counter register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && !zero) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external SR latch with a setup / enable-pulse / hold sequence,
// then checks the Q/Qn readback and reports completion.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_val,
    output logic enable,
    output logic S,
    output logic R,
    input  logic q_fb,
    input  logic qn_fb,
    output logic busy,
    output logic done,
    output logic err
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC >= (1 << CNT_W) ||
            PULSE_CYC < 1 || PULSE_CYC >= (1 << CNT_W) ||
            HOLD_CYC  < 1 || HOLD_CYC  >= (1 << CNT_W)) begin : g_bad_param
            $error("sr_latch_driver: phase lengths must be in [1, 2**CNT_W-1]");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    sr_state_t        state_r, state_nx;
    logic             target_r, target_nx_s;
    logic             err_r;
    logic             ready_r, enable_r, s_r, r_r, busy_r, done_r;
    logic             accept_s, drive_s;
    logic             load_s, dec_s, zero_s;
    logic [CNT_W-1:0] load_val_s;
    logic [CNT_W-1:0] count_s;

    sr_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .count    (count_s),
        .zero     (zero_s)
    );

    assign accept_s  = req_valid && ready_r;
    assign req_ready = ready_r;
    assign enable    = enable_r;
    assign S         = s_r;
    assign R         = r_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = done_r & err_r;

    // Next-state, counter control and next-output decode.
    always_comb begin
        state_nx    = state_r;
        load_s      = 1'b0;
        load_val_s  = {CNT_W{1'b0}};
        dec_s       = 1'b0;
        target_nx_s = accept_s ? req_val : target_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx   = ST_SETUP;
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (zero_s) begin
                    state_nx   = ST_PULSE;
                    load_s     = 1'b1;
                    load_val_s = PULSE_LD;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_PULSE: begin
                if (zero_s) begin
                    state_nx   = ST_HOLD;
                    load_s     = 1'b1;
                    load_val_s = HOLD_LD;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (zero_s) begin
                    state_nx = ST_CHECK;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_CHECK: state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        drive_s = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) || (state_nx == ST_HOLD);
    end

    // FSM state and registered outputs; S and R are complementary or both low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            target_r <= 1'b0;
            err_r    <= 1'b0;
            ready_r  <= 1'b0;
            enable_r <= 1'b0;
            s_r      <= 1'b0;
            r_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            target_r <= target_nx_s;
            if (state_r == ST_CHECK) begin
                err_r <= fb_mismatch(target_r, q_fb, qn_fb);
            end else begin
                err_r <= err_r;
            end
            ready_r  <= (state_nx == ST_IDLE);
            enable_r <= (state_nx == ST_PULSE);
            s_r      <= drive_s & target_nx_s;
            r_r      <= drive_s & ~target_nx_s;
            busy_r   <= (state_nx != ST_IDLE);
            done_r   <= (state_nx == ST_RESP);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Closed-loop bench: behavioural SR latches feed Q/Qn back into a default
// driver and a driver with SETUP=3, PULSE=1, HOLD=2.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_val = 1'b0, req_ready;
    logic enable, S, R, busy, done, err, q_fb, qn_fb;
    logic req_valid2 = 1'b0, req_val2 = 1'b0, req_ready2;
    logic enable2, S2, R2, busy2, done2, err2, q_fb2, qn_fb2;
    logic q_lat = 1'b0, q_lat2 = 1'b0;
    logic stuck_q0 = 1'b0;
    logic both_seen = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sr_latch_driver u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_val(req_val), .enable(enable), .S(S), .R(R), .q_fb(q_fb), .qn_fb(qn_fb),
        .busy(busy), .done(done), .err(err)
    );

    sr_latch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_val(req_val2), .enable(enable2), .S(S2), .R(R2), .q_fb(q_fb2), .qn_fb(qn_fb2),
        .busy(busy2), .done(done2), .err(err2)
    );

    // Behavioural SR latches, transparent while enable is high.
    always_latch begin
        if (enable) begin
            if (S) q_lat <= 1'b1;
            else if (R) q_lat <= 1'b0;
        end
    end

    always_latch begin
        if (enable2) begin
            if (S2) q_lat2 <= 1'b1;
            else if (R2) q_lat2 <= 1'b0;
        end
    end

    assign q_fb   = stuck_q0 ? 1'b0 : q_lat;
    assign qn_fb  = ~q_lat;
    assign q_fb2  = q_lat2;
    assign qn_fb2 = ~q_lat2;

    // S and R must never be high together on either driver.
    always @(posedge clk) begin
        if ((S && R) || (S2 && R2)) both_seen <= 1'b1;
        assert (!(S2 && R2));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One full request; per-cycle {enable,S,R,busy,done} against hand-derived values.
    task automatic run_op(input logic val, input logic exp_err);
        logic [4:0] exp;
        wait_ready();
        req_valid = 1'b1;
        req_val   = val;
        @(negedge clk);
        req_valid = 1'b0;
        req_val   = ~val;
        for (int c = 1; c <= 7; c++) begin
            case (c)
                1, 4:    exp = {1'b0, val, ~val, 1'b1, 1'b0};
                2, 3:    exp = {1'b1, val, ~val, 1'b1, 1'b0};
                5:       exp = 5'b00010;
                6:       exp = 5'b00011;
                default: exp = 5'b00000;
            endcase
            check($sformatf("op%0d_c%0d", val, c), {27'd0, enable, S, R, busy, done}, {27'd0, exp});
            if (c == 6) check("op_err", {31'd0, err}, {31'd0, exp_err});
            if (c == 7) check("op_ready_after", {31'd0, req_ready}, 32'd1);
            if (c < 7) @(negedge clk);
        end
    endtask

    initial begin
        int last;
        int accepts;
        int cnt;
        logic pend, pend_val;

        // Reset state
        #3;
        check("rst_outputs", {25'd0, req_ready, enable, S, R, busy, done, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_edge", {31'd0, req_ready}, 32'd1);

        // Set, then reset the latch
        run_op(1'b1, 1'b0);
        check("set_q", {30'd0, q_fb, qn_fb}, 32'd2);
        run_op(1'b0, 1'b0);
        check("clr_q", {30'd0, q_fb, qn_fb}, 32'd1);

        // Q stuck at 0: set reports err, next request is clean
        stuck_q0 = 1'b1;
        run_op(1'b1, 1'b1);
        stuck_q0 = 1'b0;
        run_op(1'b1, 1'b0);

        // Continuous req_valid with toggling req_val
        wait_ready();
        last = -1;
        accepts = 0;
        pend = 1'b0;
        pend_val = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (pend) begin
                check("busy_capture", {31'd0, S}, {31'd0, pend_val});
                pend = 1'b0;
            end
            req_val = c[0];
            if (req_ready) begin
                if (last >= 0) check("busy_spacing", c - last, 32'd7);
                last = c;
                accepts++;
                pend = 1'b1;
                pend_val = c[0];
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("busy_capture_last", {31'd0, S}, {31'd0, pend_val});
        wait_ready();
        check("busy_accepts", accepts, 32'd4);
        check("busy_final_q", {31'd0, q_fb}, 32'd1);

        // Reset during PULSE, then a clean request
        wait_ready();
        req_valid = 1'b1;
        req_val   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pulse_enable", {31'd0, enable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("pulse_rst_out", {25'd0, req_ready, enable, S, R, busy, done, err}, 32'd0);
        @(negedge clk);
        check("pulse_rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("pulse_rst_ready", {31'd0, req_ready}, 32'd1);
        run_op(1'b1, 1'b0);
        check("pulse_rst_q", {30'd0, q_fb, qn_fb}, 32'd2);

        // SETUP=3, PULSE=1, HOLD=2: done 7 cycles after the first SETUP cycle
        cnt = 0;
        while (!req_ready2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        req_valid2 = 1'b1;
        req_val2   = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        cnt = 0;
        while (!done2 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("sweep_latency", cnt, 32'd7);
        check("sweep_err", {31'd0, err2}, 32'd0);
        check("sweep_q", {30'd0, q_fb2, qn_fb2}, 32'd2);
        @(negedge clk);
        check("no_s_and_r", {31'd0, both_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
